// File: rtl/tile_blitter.sv
// tile_blitter: streams a TILE_W x TILE_H tile from a fixed-latency ROM to the
// VGA pixel-write port at one pixel per cycle, with optional X/Y mirroring.
// Addresses are issued back to back. A delay line of screen-coordinate tokens
// runs alongside the ROM latency, so every returning word meets its own
// coordinates.
// Optional feature macro: TRANSPARENCY_EN. When it is defined, pixels whose
// colour equals TRANSPARENT_KEY are not written.
module tile_blitter #(
  parameter int TILE_W      = 8,
  parameter int TILE_H      = 8,
  parameter int X_W         = 8,
  parameter int Y_W         = 8,
  parameter int ADDR_W      = 16,
  parameter int RGB_W       = 24,
  parameter int ROM_LATENCY = 5,
  parameter logic [RGB_W-1:0] TRANSPARENT_KEY = 24'hFF00FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] tile_addr,
  input  logic [X_W-1:0]    x_in,
  input  logic [Y_W-1:0]    y_in,
  input  logic              mirror_x,
  input  logic              mirror_y,
  output logic              busy,
  output logic              done,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [RGB_W-1:0]  rom_data,
  output logic              vga_draw_enable,
  output logic [X_W-1:0]    vga_x,
  output logic [Y_W-1:0]    vga_y,
  output logic [RGB_W-1:0]  vga_rgb
);

  localparam int N     = TILE_W * TILE_H;
  localparam int COL_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int ROW_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int IDX_W = $clog2(N + 1);
  localparam int L     = ROM_LATENCY;

`ifdef TRANSPARENCY_EN
  localparam bit TRANSP_ON = 1'b1;
`else
  localparam bit TRANSP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t state_q;

  // Latched tile parameters
  logic [ADDR_W-1:0] base_q;
  logic [X_W-1:0]    x0_q;
  logic [Y_W-1:0]    y0_q;
  logic              mx_q;
  logic              my_q;

  // Raster position of the address currently on rom_addr
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [IDX_W-1:0]  idx_q;

  // Registered FSM outputs
  logic              busy_q;
  logic              done_q;
  logic              rom_req_q;
  logic [ADDR_W-1:0] rom_addr_q;

  // Token that travels with the address on rom_addr
  logic              tok_valid_q;
  logic [X_W-1:0]    tok_x_q;
  logic [Y_W-1:0]    tok_y_q;

  // Output write registers
  logic              draw_q;
  logic [X_W-1:0]    vga_x_q;
  logic [Y_W-1:0]    vga_y_q;
  logic [RGB_W-1:0]  vga_rgb_q;

  // Next-pixel computation
  logic [COL_W-1:0]  col_nx_d;
  logic [ROW_W-1:0]  row_nx_d;
  logic [IDX_W-1:0]  idx_nx_d;
  logic [ADDR_W-1:0] sel_base;
  logic [X_W-1:0]    sel_x0;
  logic [Y_W-1:0]    sel_y0;
  logic              sel_mx;
  logic              sel_my;
  logic [COL_W-1:0]  sel_col;
  logic [ROW_W-1:0]  sel_row;
  logic [IDX_W-1:0]  sel_idx;
  logic [ADDR_W-1:0] issue_addr_d;
  logic [X_W-1:0]    issue_x_d;
  logic [Y_W-1:0]    issue_y_d;

  // Delay line taps
  logic [L-1:0]      dl_valid_w;
  logic [X_W-1:0]    dl_x_w [L];
  logic [Y_W-1:0]    dl_y_w [L];
  logic              dl_any_w;
  logic              write_d;

  assign busy            = busy_q;
  assign done            = done_q;
  assign rom_req         = rom_req_q;
  assign rom_addr        = rom_addr_q;
  assign vga_draw_enable = draw_q;
  assign vga_x           = vga_x_q;
  assign vga_y           = vga_y_q;
  assign vga_rgb         = vga_rgb_q;

  // Address and screen position of the next pixel to issue. The first pixel
  // comes straight from the inputs while IDLE; later pixels come from the
  // latched copies and the advanced raster counters.
  always_comb begin
    col_nx_d = (col_q == COL_W'(TILE_W - 1)) ? '0 : col_q + 1'b1;
    row_nx_d = (col_q == COL_W'(TILE_W - 1)) ? row_q + 1'b1 : row_q;
    idx_nx_d = idx_q + 1'b1;
    if (state_q == S_IDLE) begin
      sel_base = tile_addr;
      sel_x0   = x_in;
      sel_y0   = y_in;
      sel_mx   = mirror_x;
      sel_my   = mirror_y;
      sel_col  = '0;
      sel_row  = '0;
      sel_idx  = '0;
    end else begin
      sel_base = base_q;
      sel_x0   = x0_q;
      sel_y0   = y0_q;
      sel_mx   = mx_q;
      sel_my   = my_q;
      sel_col  = col_nx_d;
      sel_row  = row_nx_d;
      sel_idx  = idx_nx_d;
    end
    issue_addr_d = sel_base + ADDR_W'(sel_idx);
    issue_x_d    = sel_x0 + (sel_mx ? X_W'(TILE_W - 1) - X_W'(sel_col) : X_W'(sel_col));
    issue_y_d    = sel_y0 + (sel_my ? Y_W'(TILE_H - 1) - Y_W'(sel_row) : Y_W'(sel_row));
  end

  // Control FSM: accept a tile, issue N raster-order reads, drain, then pulse done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rom_req_q   <= 1'b0;
      rom_addr_q  <= '0;
      base_q      <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      mx_q        <= 1'b0;
      my_q        <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      idx_q       <= '0;
      tok_valid_q <= 1'b0;
      tok_x_q     <= '0;
      tok_y_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= S_ISSUE;
            busy_q      <= 1'b1;
            base_q      <= tile_addr;
            x0_q        <= x_in;
            y0_q        <= y_in;
            mx_q        <= mirror_x;
            my_q        <= mirror_y;
            col_q       <= '0;
            row_q       <= '0;
            idx_q       <= '0;
            rom_req_q   <= 1'b1;
            rom_addr_q  <= issue_addr_d;
            tok_valid_q <= 1'b1;
            tok_x_q     <= issue_x_d;
            tok_y_q     <= issue_y_d;
          end
        end
        S_ISSUE: begin
          if (idx_q == IDX_W'(N - 1)) begin
            state_q     <= S_DRAIN;
            rom_req_q   <= 1'b0;
            rom_addr_q  <= '0;
            tok_valid_q <= 1'b0;
          end else begin
            col_q       <= col_nx_d;
            row_q       <= row_nx_d;
            idx_q       <= idx_nx_d;
            rom_addr_q  <= issue_addr_d;
            tok_valid_q <= 1'b1;
            tok_x_q     <= issue_x_d;
            tok_y_q     <= issue_y_d;
          end
        end
        S_DRAIN: begin
          // Empty pipe means the last write is on the VGA port this cycle
          if (!tok_valid_q && !dl_any_w) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Coordinate delay line matching the ROM latency; the last stage lines up with rom_data
  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_stage
      logic           stage_valid_q;
      logic [X_W-1:0] stage_x_q;
      logic [Y_W-1:0] stage_y_q;
      logic           feed_valid;
      logic [X_W-1:0] feed_x;
      logic [Y_W-1:0] feed_y;

      if (gi == 0) begin : g_head
        assign feed_valid = tok_valid_q;
        assign feed_x     = tok_x_q;
        assign feed_y     = tok_y_q;
      end else begin : g_body
        assign feed_valid = dl_valid_w[gi-1];
        assign feed_x     = dl_x_w[gi-1];
        assign feed_y     = dl_y_w[gi-1];
      end

      // Advance one token per cycle; reset discards in-flight pixels
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stage_valid_q <= 1'b0;
          stage_x_q     <= '0;
          stage_y_q     <= '0;
        end else begin
          stage_valid_q <= feed_valid;
          stage_x_q     <= feed_x;
          stage_y_q     <= feed_y;
        end
      end

      assign dl_valid_w[gi] = stage_valid_q;
      assign dl_x_w[gi]     = stage_x_q;
      assign dl_y_w[gi]     = stage_y_q;
    end
  endgenerate

  assign dl_any_w = |dl_valid_w;

  // A returning pixel is written unless transparency is built in and it carries the key colour
  assign write_d = dl_valid_w[L-1] && !(TRANSP_ON && (rom_data == TRANSPARENT_KEY));

  // Registered VGA write port; coordinates and colour hold between writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      draw_q    <= 1'b0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      vga_rgb_q <= '0;
    end else begin
      draw_q <= write_d;
      if (write_d) begin
        vga_x_q   <= dl_x_w[L-1];
        vga_y_q   <= dl_y_w[L-1];
        vga_rgb_q <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_tile_blitter.sv
// Directed bench for tile_blitter with default parameters. A behavioural ROM
// with fixed latency returns {8'h00, addr}. Two addresses can be overridden
// with the transparent key. A negedge monitor logs writes, done pulses, issued
// addresses and busy. Cycle numbers are counted from the edge that samples start.
module tb_tile_blitter;

  localparam int L = 5;

`ifdef TRANSPARENCY_EN
  localparam int  EXP_KEY_STROBES = 62;
  localparam int  EXP_KEY_SLOT    = 0;
`else
  localparam int  EXP_KEY_STROBES = 64;
  localparam int  EXP_KEY_SLOT    = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] tile_addr = '0;
  logic [7:0]  x_in = '0;
  logic [7:0]  y_in = '0;
  logic        mirror_x = 1'b0;
  logic        mirror_y = 1'b0;
  logic        busy;
  logic        done;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic [23:0] rom_data;
  logic        vga_draw_enable;
  logic [7:0]  vga_x;
  logic [7:0]  vga_y;
  logic [23:0] vga_rgb;

  tile_blitter dut (
    .clk(clk), .reset(reset), .start(start), .tile_addr(tile_addr),
    .x_in(x_in), .y_in(y_in), .mirror_x(mirror_x), .mirror_y(mirror_y),
    .busy(busy), .done(done), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_data(rom_data), .vga_draw_enable(vga_draw_enable),
    .vga_x(vga_x), .vga_y(vga_y), .vga_rgb(vga_rgb)
  );

  always #5 clk = ~clk;

  // ROM model
  logic        key_on = 1'b0;
  logic [15:0] key_base = '0;
  logic [23:0] rom_pipe [L];

  function automatic logic [23:0] rom_fn(input logic [15:0] a);
    logic [15:0] k3, k10;
    k3  = key_base + 16'd3;
    k10 = key_base + 16'd10;
    if (key_on && (a == k3 || a == k10)) return 24'hFF00FF;
    return {8'h00, a};
  endfunction

  always @(posedge clk) begin
    rom_pipe[0] <= rom_fn(rom_addr);
    for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[L-1];

  // Monitor
  typedef struct packed {
    int          cyc;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [23:0] rgb;
  } wr_t;

  int          cyc = 0;
  int          cs = 0;
  wr_t         wr_q[$];
  int          done_q[$];
  logic [15:0] addr_q[$];
  int          busy_first = -1;
  int          busy_last = -1;
  int          busy_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      int  rel;
      wr_t w;
      rel = cyc - cs + 1;
      if (vga_draw_enable) begin
        w.cyc = rel; w.x = vga_x; w.y = vga_y; w.rgb = vga_rgb;
        wr_q.push_back(w);
      end
      if (done) done_q.push_back(rel);
      if (rom_req) addr_q.push_back(rom_addr);
      if (busy) begin
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
        busy_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t get_wr(input int k);
    wr_t w;
    w = '0;
    w.cyc = -1;
    if (k >= 0 && k < wr_q.size()) w = wr_q[k];
    return w;
  endfunction

  function automatic int strobe_at(input int c);
    int n = 0;
    foreach (wr_q[i]) if (wr_q[i].cyc == c) n++;
    return n;
  endfunction

  task automatic clear_logs();
    wr_q.delete();
    done_q.delete();
    addr_q.delete();
    busy_first = -1;
    busy_last = -1;
    busy_cnt = 0;
  endtask

  // Presents a tile request so that the next rising edge (cycle origin) samples it
  task automatic begin_tile(input logic [15:0] a, input logic [7:0] x, input logic [7:0] y,
                            input logic mx, input logic my, input logic hold);
    @(negedge clk);
    tile_addr = a; x_in = x; y_in = y; mirror_x = mx; mirror_y = my;
    clear_logs();
    start = 1'b1;
    @(posedge clk);
    #1;
    cs = cyc;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_q.size() == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done_q.size() != 0), 64'd1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    wr_t w;
    int  bad;
    int  n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rom_req", 64'(rom_req), 64'd0);
    chk("rst_draw", 64'(vga_draw_enable), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_vga_xy", 64'({vga_x, vga_y}), 64'd0);
    chk("rst_vga_rgb", 64'(vga_rgb), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Plain tile at (10,20)
    begin_tile(16'h0100, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0);
    wait_done(200);
    $display("tile base=0100 xy=(10,20): strobes=%0d done=%0d", wr_q.size(), done_q.size());
    chk("t1_strobes", 64'(wr_q.size()), 64'd64);
    w = get_wr(0);
    chk("t1_first_cyc", 64'(w.cyc), 64'd7);
    chk("t1_first_x", 64'(w.x), 64'd10);
    chk("t1_first_y", 64'(w.y), 64'd20);
    chk("t1_first_rgb", 64'(w.rgb), 64'h000100);
    w = get_wr(9);
    chk("t1_p9_xy", 64'({w.x, w.y}), 64'({8'd11, 8'd21}));
    chk("t1_p9_rgb", 64'(w.rgb), 64'h000109);
    w = get_wr(63);
    chk("t1_last_cyc", 64'(w.cyc), 64'd70);
    chk("t1_last_xy", 64'({w.x, w.y}), 64'({8'd17, 8'd27}));
    chk("t1_last_rgb", 64'(w.rgb), 64'h00013F);
    chk("t1_done_cnt", 64'(done_q.size()), 64'd1);
    chk("t1_done_cyc", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'd71);
    chk("t1_busy_first", 64'(busy_first), 64'd1);
    chk("t1_busy_last", 64'(busy_last), 64'd71);
    chk("t1_busy_cnt", 64'(busy_cnt), 64'd71);
    chk("t1_addr_cnt", 64'(addr_q.size()), 64'd64);
    bad = 0;
    for (int k = 0; k < wr_q.size(); k++) begin
      if (wr_q[k].cyc != k + 7 || wr_q[k].x != 8'(10 + k % 8) ||
          wr_q[k].y != 8'(20 + k / 8) || wr_q[k].rgb != 24'(32'h100 + k)) bad++;
    end
    chk("t1_raster_model", 64'(bad), 64'd0);

    // Mirroring
    begin_tile(16'h0100, 8'd10, 8'd20, 1'b1, 1'b0, 1'b0);
    wait_done(200);
    w = get_wr(0);
    $display("mirror_x first write (%0d,%0d) rgb %06h", w.x, w.y, w.rgb);
    chk("mx_first_xy", 64'({w.x, w.y}), 64'({8'd17, 8'd20}));
    chk("mx_first_rgb", 64'(w.rgb), 64'h000100);

    begin_tile(16'h0100, 8'd10, 8'd20, 1'b0, 1'b1, 1'b0);
    wait_done(200);
    w = get_wr(0);
    $display("mirror_y first write (%0d,%0d) rgb %06h", w.x, w.y, w.rgb);
    chk("my_first_xy", 64'({w.x, w.y}), 64'({8'd10, 8'd27}));

    begin_tile(16'h0100, 8'd10, 8'd20, 1'b1, 1'b1, 1'b0);
    wait_done(200);
    w = get_wr(0);
    $display("mirror_xy first write (%0d,%0d) rgb %06h", w.x, w.y, w.rgb);
    chk("mxy_first_xy", 64'({w.x, w.y}), 64'({8'd17, 8'd27}));

    // Coordinate and address wrap
    begin_tile(16'hFFF8, 8'd252, 8'd0, 1'b0, 1'b0, 1'b0);
    wait_done(200);
    $display("wrap tile: strobes=%0d", wr_q.size());
    w = get_wr(4);
    chk("wrap_p4_xy", 64'({w.x, w.y}), 64'({8'd0, 8'd0}));
    chk("wrap_p4_rgb", 64'(w.rgb), 64'h00FFFC);
    w = get_wr(8);
    chk("wrap_p8_xy", 64'({w.x, w.y}), 64'({8'd252, 8'd1}));
    chk("wrap_p8_rgb", 64'(w.rgb), 64'h000000);
    chk("wrap_p8_addr", 64'(addr_q.size() > 8 ? addr_q[8] : 16'hDEAD), 64'h0000);

    // start held high: back-to-back tiles at edges 0 and 72
    begin_tile(16'h0100, 8'd10, 8'd20, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (done_q.size() < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    repeat (80) @(negedge clk);
    $display("held start: strobes=%0d done=%0d", wr_q.size(), done_q.size());
    chk("hold_done_cnt", 64'(done_q.size()), 64'd2);
    chk("hold_done0", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'd71);
    chk("hold_done1", 64'(done_q.size() > 1 ? done_q[1] : -1), 64'd143);
    chk("hold_strobes", 64'(wr_q.size()), 64'd128);
    w = get_wr(64);
    chk("hold_t2_first_cyc", 64'(w.cyc), 64'd79);

    // start pulses while busy are ignored
    begin_tile(16'h0200, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    repeat (80) @(negedge clk);
    $display("busy start pulses: strobes=%0d done=%0d", wr_q.size(), done_q.size());
    chk("ign_strobes", 64'(wr_q.size()), 64'd64);
    chk("ign_done_cnt", 64'(done_q.size()), 64'd1);

    // Asynchronous reset mid-tile
    begin_tile(16'h0100, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    #1;
    $display("reset mid-tile: busy=%0b draw=%0b x=%0d y=%0d", busy, vga_draw_enable, vga_x, vga_y);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_draw", 64'(vga_draw_enable), 64'd0);
    chk("arst_rom", 64'({rom_req, rom_addr}), 64'd0);
    chk("arst_vga", 64'({vga_x, vga_y, vga_rgb}), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    repeat (100) @(negedge clk);
    chk("arst_no_strobes", 64'(wr_q.size()), 64'd0);
    chk("arst_no_done", 64'(done_q.size()), 64'd0);
    begin_tile(16'h0100, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0);
    wait_done(200);
    $display("after reset: strobes=%0d first cycle %0d", wr_q.size(), get_wr(0).cyc);
    chk("arst_fresh_first_cyc", 64'(get_wr(0).cyc), 64'd7);
    chk("arst_fresh_strobes", 64'(wr_q.size()), 64'd64);
    chk("arst_fresh_done", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'd71);

    // Transparent key at idx 3 and 10
    key_on = 1'b1;
    key_base = 16'h0100;
    begin_tile(16'h0100, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0);
    wait_done(200);
    key_on = 1'b0;
    $display("key tile: strobes=%0d done=%0d", wr_q.size(), done_q.size());
    chk("key_strobes", 64'(wr_q.size()), 64'(EXP_KEY_STROBES));
    chk("key_slot10", 64'(strobe_at(10)), 64'(EXP_KEY_SLOT));
    chk("key_slot17", 64'(strobe_at(17)), 64'(EXP_KEY_SLOT));
    chk("key_slot11", 64'(strobe_at(11)), 64'd1);
    chk("key_done_cyc", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'd71);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
